// File: rtl/sd_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : sd_dac_tx
// Brief    : First-order sigma-delta DAC transmitter with a one-entry sample
//            buffer, fixed oversampling frame and underrun accounting.
// Revision : 1.0 - initial release
// ============================================================================
module sd_dac_tx #(
    parameter int DATA_BITS    = 7,
    parameter int OSR          = 128,
    parameter int UNDERRUN_MID = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] sample_data,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 dac_out,
    output logic                 running,
    output logic [15:0]          underrun_count
);

    localparam int                   c_CNT_W   = (OSR > 1) ? $clog2(OSR) : 1;
    localparam logic [c_CNT_W-1:0]   c_LAST    = c_CNT_W'(OSR - 1);
    localparam logic [DATA_BITS-1:0] c_MID     = DATA_BITS'(1) << (DATA_BITS - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PRIME = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;

    logic [1:0]           r_state;
    logic                 r_buf_valid;
    logic [DATA_BITS-1:0] r_buf;
    logic [DATA_BITS-1:0] r_cur;
    logic [DATA_BITS-1:0] r_acc;
    logic [c_CNT_W-1:0]   r_fcnt;
    logic                 r_dac;
    logic [15:0]          r_under;

    logic                 w_xfer;
    logic                 w_tick;
    logic [DATA_BITS:0]   w_sum;
    logic [15:0]          w_under_next;

    assign w_xfer       = sample_valid && !r_buf_valid;
    assign w_tick       = (r_state == c_ST_RUN) && (r_fcnt == c_LAST);
    assign w_sum        = {1'b0, r_acc} + {1'b0, r_cur};
    assign w_under_next = (r_under == 16'hFFFF) ? r_under : r_under + 16'd1;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_buf_valid <= 1'b0;
            r_buf       <= '0;
            r_cur       <= '0;
            r_acc       <= '0;
            r_fcnt      <= '0;
            r_dac       <= 1'b0;
            r_under     <= '0;
        end else begin
            if (w_xfer) begin
                r_buf_valid <= 1'b1;
                r_buf       <= sample_data;
            end
            if (!enable) begin
                r_state <= c_ST_IDLE;
                r_fcnt  <= '0;
                r_acc   <= '0;
                r_dac   <= 1'b0;
                // Flush only on leaving an active state so IDLE can pre-load a sample.
                if (r_state != c_ST_IDLE) begin
                    r_buf_valid <= 1'b0;
                end
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        r_fcnt  <= '0;
                        r_acc   <= '0;
                        r_dac   <= 1'b0;
                        r_state <= c_ST_PRIME;
                    end
                    c_ST_PRIME: begin
                        if (r_buf_valid) begin
                            r_cur       <= r_buf;
                            r_buf_valid <= 1'b0;
                            r_fcnt      <= '0;
                            r_state     <= c_ST_RUN;
                        end
                    end
                    c_ST_RUN: begin
                        // Carry out of the accumulator is the pulse-density bit.
                        r_acc <= w_sum[DATA_BITS-1:0];
                        r_dac <= w_sum[DATA_BITS];
                        if (w_tick) begin
                            r_fcnt <= '0;
                            if (r_buf_valid) begin
                                r_cur       <= r_buf;
                                r_buf_valid <= 1'b0;
                            end else begin
                                r_under <= w_under_next;
                                if (UNDERRUN_MID != 0) begin
                                    r_cur <= c_MID;
                                end
                            end
                        end else begin
                            r_fcnt <= r_fcnt + c_CNT_W'(1);
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign sample_ready   = !r_buf_valid;
    assign running        = (r_state == c_ST_RUN);
    assign dac_out        = r_dac;
    assign underrun_count = r_under;

endmodule
`default_nettype wire

// File: tb/tb_sd_dac_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_dac_tx
// Brief    : Self-checking bench for sd_dac_tx with an arithmetic stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_dac_tx;

    localparam int N    = 7;
    localparam int OSR  = 128;
    localparam int FULL = 1 << N;
    localparam int MIDP = 0;
    localparam int MID  = FULL / 2;

    logic         clock;
    logic         reset;
    logic         enable;
    logic [N-1:0] sample_data;
    logic         sample_valid;
    logic         sample_ready;
    logic         dac_out;
    logic         running;
    logic [15:0]  underrun_count;

    int n_cmp  = 0;
    int n_fail = 0;

    sd_dac_tx #(
        .DATA_BITS    (N),
        .OSR          (OSR),
        .UNDERRUN_MID (MIDP)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .sample_data    (sample_data),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .dac_out        (dac_out),
        .running        (running),
        .underrun_count (underrun_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the output bit is the change in floor(total_input / 2^N).
    int     m_buf[$];
    int     m_cur;
    int     m_pos;
    int     m_under;
    int     m_phase;   // 0 off, 1 waiting for first sample, 2 streaming
    longint m_sum;
    bit     m_dac;
    bit     m_live = 1'b0;

    always @(posedge clock) begin : model
        bit had;
        bit xfer;
        had  = (m_buf.size() != 0);
        xfer = sample_valid && !had;
        if (!reset) begin
            m_live  = 1'b1;
            m_buf.delete();
            m_cur   = 0;
            m_pos   = 0;
            m_under = 0;
            m_phase = 0;
            m_sum   = 0;
            m_dac   = 1'b0;
        end else if (!enable) begin
            if (m_phase != 0) m_buf.delete();
            else if (xfer) m_buf.push_back(int'(sample_data));
            m_phase = 0;
            m_sum   = 0;
            m_pos   = 0;
            m_dac   = 1'b0;
        end else begin
            case (m_phase)
                0: m_phase = 1;
                1: if (had) begin
                    m_cur   = m_buf.pop_front();
                    m_pos   = 0;
                    m_phase = 2;
                end
                default: begin
                    m_dac = ((m_sum + m_cur) / FULL) != (m_sum / FULL);
                    m_sum = m_sum + m_cur;
                    if (m_pos == OSR - 1) begin
                        m_pos = 0;
                        if (had) m_cur = m_buf.pop_front();
                        else begin
                            if (m_under < 65535) m_under++;
                            if (MIDP != 0) m_cur = MID;
                        end
                    end else begin
                        m_pos++;
                    end
                end
            endcase
            if (xfer) m_buf.push_back(int'(sample_data));
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            check("ready",    sample_ready,   m_buf.size() == 0);
            check("running",  running,        m_phase == 2);
            check("dac_out",  dac_out,        m_dac);
            check("underrun", underrun_count, m_under);
        end
    end

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic wait_running();
        int n = 0;
        while (!running && n < 300) begin
            step();
            n++;
        end
        check("running_timeout", running, 1);
    endtask

    task automatic count_frame(output int ones);
        ones = 0;
        repeat (OSR) begin
            step();
            ones += int'(dac_out);
        end
    endtask

    task automatic push_hs(input int v);
        int  n   = 0;
        bit  acc = 1'b0;
        sample_valid = 1'b1;
        sample_data  = N'(v);
        while (!acc && n < 400) begin
            acc = sample_ready;
            step();
            n++;
        end
        sample_valid = 1'b0;
        check("push_timeout", acc, 1);
    endtask

    task automatic restart();
        enable = 1'b0;
        step();
        step();
        enable = 1'b1;
        step();
    endtask

    task automatic run_density(input int code, input int exp);
        int ones;
        restart();
        sample_valid = 1'b1;
        sample_data  = N'(code);
        step();
        sample_valid = 1'b0;
        check("running_at_E", running, 0);
        step();
        check("running_at_E1", running, 1);
        count_frame(ones);
        check("density", ones, exp);
    endtask

    initial begin
        int ones;
        reset        = 1'b0;
        enable       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_dac", dac_out, 0);
        check("rst_running", running, 0);
        check("rst_ready", sample_ready, 1);
        check("rst_under", underrun_count, 0);
        reset = 1'b1;
        repeat (4) begin
            step();
            check("idle_dac", dac_out, 0);
            check("idle_running", running, 0);
        end

        run_density(32, 32);
        run_density(0, 0);
        run_density(127, 127);
        check("under_after_density", underrun_count, 3);

        restart();
        fork
            begin
                push_hs(5);
                push_hs(64);
                push_hs(100);
            end
            begin
                int f;
                wait_running();
                count_frame(f);
                check("stream_f1", f, 5);
                check("stream_u1", underrun_count, 3);
                count_frame(f);
                check("stream_f2", f, 64);
                check("stream_u2", underrun_count, 3);
                count_frame(f);
                check("stream_f3", f, 100);
                check("stream_u3", underrun_count, 4);
            end
        join

        restart();
        sample_valid = 1'b1;
        sample_data  = N'(40);
        step();
        sample_valid = 1'b0;
        wait_running();
        for (int k = 1; k <= 3; k++) begin
            count_frame(ones);
            check("underrun_ones", ones, 40);
            check("underrun_cnt", underrun_count, 4 + k);
        end

        // Sample presented exactly on the tick edge with an empty buffer.
        ones = 0;
        repeat (OSR - 1) begin
            step();
            ones += int'(dac_out);
        end
        sample_valid = 1'b1;
        sample_data  = N'(20);
        step();
        ones += int'(dac_out);
        sample_valid = 1'b0;
        check("sim_f4", ones, 40);
        check("sim_u4", underrun_count, 8);
        check("sim_ready", sample_ready, 0);
        count_frame(ones);
        check("sim_f5", ones, 40);
        check("sim_u5", underrun_count, 8);
        count_frame(ones);
        check("sim_f6", ones, 20);
        check("sim_u6", underrun_count, 9);

        sample_valid = 1'b1;
        sample_data  = N'(77);
        step();
        sample_valid = 1'b0;
        repeat (49) step();
        check("pre_drop_ready", sample_ready, 0);
        enable = 1'b0;
        step();
        check("drop_running", running, 0);
        check("drop_dac", dac_out, 0);
        check("drop_ready", sample_ready, 1);
        check("drop_under", underrun_count, 9);

        enable = 1'b1;
        step();
        sample_valid = 1'b1;
        sample_data  = N'(90);
        step();
        sample_valid = 1'b0;
        wait_running();
        repeat (40) step();
        sample_valid = 1'b1;
        sample_data  = N'(91);
        step();
        sample_valid = 1'b0;
        check("pre_rst_ready", sample_ready, 0);
        repeat (10) step();
        reset = 1'b0;
        step();
        check("mid_rst_running", running, 0);
        check("mid_rst_dac", dac_out, 0);
        check("mid_rst_ready", sample_ready, 1);
        check("mid_rst_under", underrun_count, 0);
        reset  = 1'b1;
        enable = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
